// File: rtl/ssd_scan_scheduler.sv
// Scan scheduler for an 8-digit multiplexed seven-segment display: per-slot blanking,
// two-requester content arbitration through one pending slot, frame-aligned commit.
module ssd_scan_scheduler #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int DIGIT_HZ  = 8_000,
  parameter int BLANK_CYC = 100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_a_valid,
  input  logic [31:0] req_a_data,
  input  logic [7:0]  req_a_dp,
  input  logic [7:0]  req_a_mask,
  output logic        req_a_ready,
  input  logic        req_b_valid,
  input  logic [31:0] req_b_data,
  input  logic [7:0]  req_b_dp,
  input  logic [7:0]  req_b_mask,
  output logic        req_b_ready,
  output logic        frame_start,
  output logic [2:0]  cur_digit,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int DIV    = CLK_HZ / DIGIT_HZ;
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(DIV - 1);
  localparam logic [TICK_W-1:0] TICK_BLANK = TICK_W'(BLANK_CYC);

  if (DIV <= BLANK_CYC + 1) begin : gBadTiming
    $error("ssd_scan_scheduler: DIV must exceed BLANK_CYC+1");
  end

  logic [TICK_W-1:0] tick_p0;
  logic [2:0]        digit_p0;
  logic              frameEnd;
  logic              pendFull;
  logic [31:0]       pendData;
  logic [7:0]        pendDp;
  logic [7:0]        pendMask;
  logic [31:0]       actData;
  logic [7:0]        actDp;
  logic [7:0]        actMask;
  logic              acceptA;
  logic              acceptB;
  logic              litVld_p0;
  logic [3:0]        nibble_p0;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign frameEnd    = (tick_p0 == TICK_LAST) && (digit_p0 == 3'd7);
  assign req_a_ready = !pendFull;
  assign req_b_ready = !pendFull && !req_a_valid;
  assign acceptA     = req_a_valid && req_a_ready;
  assign acceptB     = req_b_valid && req_b_ready;
  assign cur_digit   = digit_p0;
  assign nibble_p0   = actData[{digit_p0, 2'b00} +: 4];
  assign litVld_p0   = (tick_p0 >= TICK_BLANK) && actMask[digit_p0];

  // Stage p0: slot tick and digit scan counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_p0  <= '0;
      digit_p0 <= 3'd0;
    end else if (tick_p0 == TICK_LAST) begin
      tick_p0  <= '0;
      digit_p0 <= digit_p0 + 3'd1;
    end else begin
      tick_p0  <= tick_p0 + 1'b1;
    end
  end

  // Commit and accept are exclusive: ready is low whenever a commit is possible.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pendFull <= 1'b0;
      pendData <= '0;
      pendDp   <= '0;
      pendMask <= '0;
      actData  <= '0;
      actDp    <= '0;
      actMask  <= '0;
    end else if (frameEnd && pendFull) begin
      actData  <= pendData;
      actDp    <= pendDp;
      actMask  <= pendMask;
      pendFull <= 1'b0;
    end else if (acceptA) begin
      pendData <= req_a_data;
      pendDp   <= req_a_dp;
      pendMask <= req_a_mask;
      pendFull <= 1'b1;
    end else if (acceptB) begin
      pendData <= req_b_data;
      pendDp   <= req_b_dp;
      pendMask <= req_b_mask;
      pendFull <= 1'b1;
    end
  end

  // Stage p1: registered anode/cathode drive
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      an          <= 8'hFF;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frameEnd;
      if (litVld_p0) begin
        an  <= ~(8'b1 << digit_p0);
        seg <= hex7(nibble_p0);
        dp  <= ~actDp[digit_p0];
      end else begin
        an  <= 8'hFF;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end
    end
  end

endmodule
